// File: rtl/sha256_multiblock_if.sv
// Memory-port and control bundle for sha256_multiblock.
// master = the hasher; slave = memory/controller side.
interface sha256_multiblock_if;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  start, message_addr, output_addr, mem_read_data,
    output done, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    output start, message_addr, output_addr, mem_read_data,
    input  done, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha256_multiblock.sv
// SHA-256 over NUM_OF_WORDS memory words with internal padding; digest written back to memory.
// Latency 66*NUM_BLOCKS+8 cycles from accepted start; start is ignored while busy (done low).
module sha256_multiblock #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sha256_multiblock_if.master   bus
);

  localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam logic [11:0] MSG_WORDS  = 12'(NUM_OF_WORDS);
  localparam logic [11:0] LEN_IDX    = 12'(16 * NUM_BLOCKS - 1);
  localparam logic [31:0] LEN_BITS   = 32'(32 * NUM_OF_WORDS);
  localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {IDLE, BLOCK, COMPUTE, UPDATE, WRITE} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t      state, state_nxt;
  logic [5:0]  t;
  logic [7:0]  blk;
  logic [2:0]  k;
  logic [15:0] msg_base;
  logic [15:0] out_base;
  logic [31:0] h_reg [8];
  logic [31:0] va, vb, vc, vd, ve, vf, vg, vh;
  logic [31:0] w_buf [16];

  logic [11:0] g_idx;
  logic [15:0] blk_addr;
  logic [31:0] w_msg, w_sched, w_t, t1, t2;

  assign g_idx    = {blk, t[3:0]};
  assign blk_addr = msg_base + {4'b0, blk, 4'b0};

  // Padding and length words are synthesised here instead of being fetched.
  always_comb begin
    w_msg = 32'h0;
    if (g_idx < MSG_WORDS)
      w_msg = bus.mem_read_data;
    else if (g_idx == MSG_WORDS)
      w_msg = 32'h80000000;
    else if (g_idx == LEN_IDX)
      w_msg = LEN_BITS;
  end

  // w_buf[0] holds W[t-16], w_buf[15] holds W[t-1].
  assign w_sched = w_buf[0] + sig0(w_buf[1]) + w_buf[9] + sig1(w_buf[14]);
  assign w_t     = (t[5:4] == 2'b00) ? w_msg : w_sched;
  assign t1      = vh + ep1(ve) + ((ve & vf) ^ (~ve & vg)) + K[t] + w_t;
  assign t2      = ep0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));

  assign bus.done    = (state == IDLE);
  assign bus.mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Memory outputs decode straight from state so reset silences them immediately.
  always_comb begin
    state_nxt          = state;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = 16'h0;
    bus.mem_write_data = 32'h0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = BLOCK;
      end
      BLOCK: begin
        bus.mem_addr = blk_addr;
        state_nxt    = COMPUTE;
      end
      COMPUTE: begin
        if (t < 6'd15)
          bus.mem_addr = blk_addr + {10'b0, t} + 16'd1;
        if (t == 6'd63)
          state_nxt = UPDATE;
      end
      UPDATE: begin
        state_nxt = (blk == LAST_BLK) ? WRITE : BLOCK;
      end
      WRITE: begin
        bus.mem_we         = 1'b1;
        bus.mem_addr       = out_base + {13'b0, k};
        bus.mem_write_data = h_reg[k];
        if (k == 3'd7)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t        <= 6'd0;
      blk      <= 8'd0;
      k        <= 3'd0;
      msg_base <= 16'h0;
      out_base <= 16'h0;
      va <= 32'h0; vb <= 32'h0; vc <= 32'h0; vd <= 32'h0;
      ve <= 32'h0; vf <= 32'h0; vg <= 32'h0; vh <= 32'h0;
      for (int i = 0; i < 8; i++)
        h_reg[i] <= 32'h0;
      for (int i = 0; i < 16; i++)
        w_buf[i] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            msg_base <= bus.message_addr;
            out_base <= bus.output_addr;
            blk      <= 8'd0;
            k        <= 3'd0;
            for (int i = 0; i < 8; i++)
              h_reg[i] <= IV[i];
          end
        end
        BLOCK: begin
          t  <= 6'd0;
          va <= h_reg[0]; vb <= h_reg[1]; vc <= h_reg[2]; vd <= h_reg[3];
          ve <= h_reg[4]; vf <= h_reg[5]; vg <= h_reg[6]; vh <= h_reg[7];
        end
        COMPUTE: begin
          t  <= t + 6'd1;
          vh <= vg;
          vg <= vf;
          vf <= ve;
          ve <= vd + t1;
          vd <= vc;
          vc <= vb;
          vb <= va;
          va <= t1 + t2;
          for (int i = 0; i < 15; i++)
            w_buf[i] <= w_buf[i + 1];
          w_buf[15] <= w_t;
        end
        UPDATE: begin
          h_reg[0] <= h_reg[0] + va;
          h_reg[1] <= h_reg[1] + vb;
          h_reg[2] <= h_reg[2] + vc;
          h_reg[3] <= h_reg[3] + vd;
          h_reg[4] <= h_reg[4] + ve;
          h_reg[5] <= h_reg[5] + vf;
          h_reg[6] <= h_reg[6] + vg;
          h_reg[7] <= h_reg[7] + vh;
          k        <= 3'd0;
          if (blk != LAST_BLK)
            blk <= blk + 8'd1;
        end
        WRITE: begin
          k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Directed bench: six engine instances (different NUM_OF_WORDS) share one word memory.
// Digests are checked against known vectors and an independent software SHA-256.
module tb_sha256_multiblock;

  function automatic int nw_of(input int i);
    case (i)
      0: return 1;
      1: return 20;
      2: return 13;
      3: return 14;
      4: return 16;
      default: return 30;
    endcase
  endfunction

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] ABCD_DIGEST [8] = '{
    32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
    32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
  };

  logic        clk;
  logic        reset_n;
  logic [15:0] msg_addr;
  logic [15:0] out_addr;
  logic        start_a [6];
  logic        done_a  [6];
  logic        we_a    [6];
  logic [15:0] addr_a  [6];
  logic [31:0] wd_a    [6];

  int          sel;
  logic        cur_we;
  logic [15:0] cur_addr;
  logic [31:0] cur_wd;
  logic [31:0] rd_q;
  logic [31:0] mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        wr_clr;
  int          wr_cnt;
  logic [15:0] wr_log [8];

  logic [31:0] msg   [0:63];
  logic [31:0] exp_h [0:7];
  logic [31:0] first_h [0:7];
  int          n_assert;
  int          n_fail;
  int          lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 6; gi++) begin : g_dut
    sha256_multiblock_if bus ();
    assign bus.start         = start_a[gi];
    assign bus.message_addr  = msg_addr;
    assign bus.output_addr   = out_addr;
    assign bus.mem_read_data = rd_q;
    assign done_a[gi]        = bus.done;
    assign we_a[gi]          = bus.mem_we;
    assign addr_a[gi]        = bus.mem_addr;
    assign wd_a[gi]          = bus.mem_write_data;

    sha256_multiblock #(.NUM_OF_WORDS(nw_of(gi))) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  always_comb begin
    cur_we   = we_a[sel];
    cur_addr = addr_a[sel];
    cur_wd   = wd_a[sel];
  end

  // Synchronous-read memory plus a log of the write stream.
  always @(posedge clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (cur_we)
      mem[cur_addr] <= cur_wd;
    rd_q <= mem[cur_addr];
    if (wr_clr)
      wr_cnt <= 0;
    else if (cur_we) begin
      if (wr_cnt < 8)
        wr_log[wr_cnt[2:0]] <= cur_addr;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input int nw);
    logic [31:0] pw [0:63];
    logic [31:0] ww [0:63];
    logic [31:0] hv [0:7];
    logic [31:0] s  [0:7];
    logic [31:0] x1, x2, s0w, s1w;
    int nb;
    nb = (nw + 2) / 16 + 1;
    for (int i = 0; i < 16 * nb; i++) begin
      if (i < nw) pw[i] = msg[i];
      else if (i == nw) pw[i] = 32'h80000000;
      else if (i == 16 * nb - 1) pw[i] = 32'(32 * nw);
      else pw[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) hv[i] = IV[i];
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 64; j++) begin
        if (j < 16) ww[j] = pw[16 * bi + j];
        else begin
          s0w = rotr(ww[j-15], 7) ^ rotr(ww[j-15], 18) ^ (ww[j-15] >> 3);
          s1w = rotr(ww[j-2], 17) ^ rotr(ww[j-2], 19) ^ (ww[j-2] >> 10);
          ww[j] = ww[j-16] + s0w + ww[j-7] + s1w;
        end
      end
      for (int i = 0; i < 8; i++) s[i] = hv[i];
      for (int j = 0; j < 64; j++) begin
        x1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[j] + ww[j];
        x2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        for (int i = 7; i > 0; i--) s[i] = s[i-1];
        s[4] = s[4] + x1;
        s[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) hv[i] = hv[i] + s[i];
    end
    for (int i = 0; i < 8; i++) exp_h[i] = hv[i];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill_msg(input int nw, input logic [15:0] base);
    for (int i = 0; i < nw; i++) begin
      msg[i] = $urandom;
      load(16'(base + i), msg[i]);
    end
  endtask

  task automatic clear_out(input logic [15:0] base);
    for (int i = 0; i < 8; i++) load(16'(base + i), 32'h0);
  endtask

  task automatic chk_digest(input string tag, input logic [15:0] base);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_h%0d", tag, i), mem[16'(base + i)], exp_h[i]);
  endtask

  // Starts instance idx at a falling edge and counts falling edges that see done low.
  task automatic run(input int idx, input int hold, output int cycles);
    int c;
    cycles = 0;
    c = 0;
    start_a[idx] = 1'b1;
    wr_clr = 1'b1;
    do begin
      @(negedge clk);
      c++;
      wr_clr = 1'b0;
      if (c >= hold) start_a[idx] = 1'b0;
      if (done_a[idx]) break;
      cycles++;
    end while (c < 2000);
    start_a[idx] = 1'b0;
  endtask

  initial begin
    int lat_exp;
    int nw;
    n_assert = 0; n_fail = 0;
    sel = 1; ld_en = 1'b0; ld_addr = 16'h0; ld_data = 32'h0; wr_clr = 1'b0;
    msg_addr = 16'h0; out_addr = 16'h0;
    for (int i = 0; i < 6; i++) start_a[i] = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(done_a[1]), 32'd1);
    chk("reset_we", 32'(we_a[1]), 32'd0);
    chk("reset_addr", 32'(addr_a[1]), 32'd0);
    chk("reset_wdata", wd_a[1], 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-word "abcd" against the published digest.
    sel = 0; msg_addr = 16'h0010; out_addr = 16'h0200;
    load(16'h0010, 32'h61626364);
    run(0, 1, lat);
    chk("abcd_latency", 32'(lat), 32'd74);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abcd_h%0d", i), mem[16'(16'h0200 + i)], ABCD_DIGEST[i]);

    // 20 words, plus the write stream address order.
    sel = 1; msg_addr = 16'h0000; out_addr = 16'h0100;
    fill_msg(20, 16'h0000); model(20);
    run(1, 1, lat);
    chk("w20_latency", 32'(lat), 32'd140);
    chk_digest("w20", 16'h0100);
    chk("w20_write_count", 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("w20_waddr%0d", i), 32'(wr_log[i]), 32'(16'h0100 + i));

    // Padding boundaries.
    for (int i = 2; i < 6; i++) begin
      nw = nw_of(i);
      lat_exp = (i == 2) ? 74 : (i == 5) ? 206 : 140;
      sel = i; msg_addr = 16'h0300; out_addr = 16'h0400;
      fill_msg(nw, 16'h0300); model(nw);
      run(i, 1, lat);
      chk($sformatf("pad%0d_latency", nw), 32'(lat), 32'(lat_exp));
      chk_digest($sformatf("pad%0d", nw), 16'h0400);
    end

    // Message wrapping past the top of the address space.
    sel = 1; msg_addr = 16'hFFFE; out_addr = 16'h0500;
    fill_msg(20, 16'hFFFE); model(20);
    run(1, 1, lat);
    chk("wrap_latency", 32'(lat), 32'd140);
    chk_digest("wrap", 16'h0500);

    // Reset during COMPUTE of block 1, then a clean rerun.
    msg_addr = 16'h0000; out_addr = 16'h0600;
    fill_msg(20, 16'h0000); model(20); clear_out(16'h0600);
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (79) @(negedge clk);
    chk("rstc_busy", 32'(done_a[1]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstc_we", 32'(we_a[1]), 32'd0);
    chk("rstc_done", 32'(done_a[1]), 32'd1);
    chk("rstc_addr", 32'(addr_a[1]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(1, 1, lat);
    chk("rstc_rerun_latency", 32'(lat), 32'd140);
    chk_digest("rstc_rerun", 16'h0600);

    // Reset during WRITE of word 3.
    clear_out(16'h0600);
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (135) @(negedge clk);
    chk("rstw_we_before", 32'(we_a[1]), 32'd1);
    chk("rstw_addr_before", 32'(addr_a[1]), 32'h0603);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_we", 32'(we_a[1]), 32'd0);
    chk("rstw_done", 32'(done_a[1]), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    clear_out(16'h0600);
    run(1, 1, lat);
    chk("rstw_rerun_latency", 32'(lat), 32'd140);
    chk_digest("rstw_rerun", 16'h0600);

    // Start held for 3 cycles, then restarted the cycle done returns.
    clear_out(16'h0600);
    run(1, 3, lat);
    chk("hold_latency", 32'(lat), 32'd140);
    chk("hold_write_count", 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++) first_h[i] = mem[16'(16'h0600 + i)];
    chk_digest("hold", 16'h0600);
    run(1, 1, lat);
    chk("restart_latency", 32'(lat), 32'd140);
    chk("restart_write_count", 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("restart_h%0d", i), mem[16'(16'h0600 + i)], first_h[i]);
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!done_a[1]) lat++;
    end
    chk("restart_idle_after", 32'(lat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
